// File: rtl/master_spi_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM encoding and frame constants
// that the companion slave block uses as well.
package master_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    localparam logic        SPI_CPOL   = 1'b0;
    localparam int unsigned FRAME_BITS = 8;

endpackage

// File: rtl/master_spi_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module master_spi_sync_2ff (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/master_spi.sv
// SPI mode-0 master: one full-duplex 8-bit frame per accepted Start_i, with CS
// setup/hold and an inter-frame gap of HALF_PERIOD clocks each.
module master_spi
    import master_spi_pkg::*;
#(
    parameter int HALF_PERIOD = 197,
    parameter int BITS        = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Start_i,
    input  logic [BITS-1:0] Data_i,
    output logic [BITS-1:0] Data_o,
    output logic            Busy_o,
    output logic            Done_o,
    output logic            CS_o,
    output logic            SCK_o,
    output logic            MOSI_o,
    input  logic            MISO_i
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      bit_reg, bit_next;
    logic [BITS-1:0] tx_reg, tx_next;
    logic [BITS-1:0] rx_reg, rx_next;
    logic [BITS-1:0] data_reg, data_next;
    logic            cs_reg, cs_next;
    logic            sck_reg, sck_next;
    logic            mosi_reg, mosi_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            miso_sync;
    logic            phase_end;
    logic            last_bit;

    master_spi_sync_2ff u_sync (
        .Clock (Clock),
        .Reset (Reset),
        .d     (MISO_i),
        .q     (miso_sync)
    );

    assign phase_end = (cnt_reg == CW'(HALF_PERIOD - 1));
    assign last_bit  = (bit_reg == 3'(FRAME_BITS - 1));

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (Start_i)   state_next = ST_SETUP;
            ST_SETUP: if (phase_end) state_next = ST_HIGH;
            ST_HIGH:  if (phase_end) state_next = last_bit ? ST_HOLD : ST_LOW;
            ST_LOW:   if (phase_end) state_next = ST_HIGH;
            ST_HOLD:  if (phase_end) state_next = ST_GAP;
            ST_GAP:   if (phase_end) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Pin and datapath updates are computed here and registered below, so
    // every output is a flop and changes exactly on a phase boundary.
    always_comb begin
        cnt_next  = (state_reg == ST_IDLE || phase_end) ? '0 : cnt_reg + 1'b1;
        bit_next  = bit_reg;
        tx_next   = tx_reg;
        rx_next   = rx_reg;
        data_next = data_reg;
        cs_next   = cs_reg;
        sck_next  = sck_reg;
        mosi_next = mosi_reg;
        busy_next = busy_reg;
        done_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (Start_i) begin
                    cs_next   = 1'b0;
                    mosi_next = Data_i[BITS-1];
                    tx_next   = Data_i;
                    busy_next = 1'b1;
                    bit_next  = '0;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (phase_end) sck_next = ~SPI_CPOL;
            end
            ST_HIGH: begin
                if (phase_end) begin
                    rx_next  = {rx_reg[BITS-2:0], miso_sync};
                    sck_next = SPI_CPOL;
                    if (last_bit) begin
                        bit_next = '0;
                    end else begin
                        bit_next  = bit_reg + 1'b1;
                        tx_next   = {tx_reg[BITS-2:0], 1'b0};
                        mosi_next = tx_reg[BITS-2];
                    end
                end
            end
            ST_HOLD: begin
                if (phase_end) begin
                    cs_next   = 1'b1;
                    mosi_next = 1'b0;
                    done_next = 1'b1;
                    data_next = rx_reg;
                end
            end
            ST_GAP: begin
                if (phase_end) busy_next = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt_reg  <= '0;
            bit_reg  <= '0;
            tx_reg   <= '0;
            rx_reg   <= '0;
            data_reg <= '0;
            cs_reg   <= 1'b1;
            sck_reg  <= SPI_CPOL;
            mosi_reg <= 1'b0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            bit_reg  <= bit_next;
            tx_reg   <= tx_next;
            rx_reg   <= rx_next;
            data_reg <= data_next;
            cs_reg   <= cs_next;
            sck_reg  <= sck_next;
            mosi_reg <= mosi_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    assign Data_o = data_reg;
    assign Busy_o = busy_reg;
    assign Done_o = done_reg;
    assign CS_o   = cs_reg;
    assign SCK_o  = sck_reg;
    assign MOSI_o = mosi_reg;

endmodule

// File: tb/tb_master_spi.sv
// Directed bench for master_spi with HALF_PERIOD=4; pins are checked cycle by
// cycle against a timing model built from the frame formulas.
module tb_master_spi;

    localparam int H = 4;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start_i;
    logic [7:0] Data_i;
    logic [7:0] Data_o;
    logic       Busy_o;
    logic       Done_o;
    logic       CS_o;
    logic       SCK_o;
    logic       MOSI_o;
    logic       MISO_i;
    logic       loop_en;
    logic       miso_val;

    int vectors     = 0;
    int miscompares = 0;

    assign MISO_i = loop_en ? MOSI_o : miso_val;

    always #5 Clock = ~Clock;

    master_spi #(.HALF_PERIOD(H), .BITS(8)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start_i (Start_i),
        .Data_i  (Data_i),
        .Data_o  (Data_o),
        .Busy_o  (Busy_o),
        .Done_o  (Done_o),
        .CS_o    (CS_o),
        .SCK_o   (SCK_o),
        .MOSI_o  (MOSI_o),
        .MISO_i  (MISO_i)
    );

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Expected {CS, SCK, MOSI, Busy, Done} for cycle c (1 = cycle after accept).
    function automatic logic [4:0] exp_pins(input int c, input logic [7:0] d);
        logic cs, sck, mosi, busy, done;
        int j;
        cs  = (c >= 1 + 17*H);
        sck = 1'b0;
        for (int k = 0; k < 8; k++)
            if (c >= 1 + (2*k+1)*H && c < 1 + (2*k+2)*H) sck = 1'b1;
        j = 0;
        for (int k = 0; k < 7; k++)
            if (c >= 1 + (2*k+2)*H) j++;
        mosi = (c < 1 + 17*H) ? d[7-j] : 1'b0;
        busy = (c < 1 + 18*H);
        done = (c == 1 + 17*H);
        return {cs, sck, mosi, busy, done};
    endfunction

    // mode 0: loopback, 1: MISO tied high, 2: MISO tied low.
    task automatic run_frame(input logic [7:0] d, input int mode,
                             input int pulse_at, input string name);
        logic [7:0] exp_rx;
        logic [4:0] got, want;
        int extra_bad;
        loop_en  = (mode == 0);
        miso_val = (mode == 1);
        exp_rx   = (mode == 0) ? d : ((mode == 1) ? 8'hFF : 8'h00);
        Data_i   = d;
        Start_i  = 1'b1;
        tick();
        Start_i = 1'b0;
        Data_i  = ~d;
        for (int c = 1; c <= 1 + 18*H; c++) begin
            got  = {CS_o, SCK_o, MOSI_o, Busy_o, Done_o};
            want = exp_pins(c, d);
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s pins cycle %0d: got cs/sck/mosi/busy/done=%b expected %b",
                         name, c, got, want);
            end
            if (c >= 1 + 17*H) begin
                vectors++;
                if (Data_o !== exp_rx) begin
                    miscompares++;
                    $display("FAIL %s data_o cycle %0d: got %h expected %h", name, c, Data_o, exp_rx);
                end
            end
            if (pulse_at != 0 && c == pulse_at) begin
                Start_i = 1'b1;
                Data_i  = 8'hAA;
            end else if (pulse_at != 0 && c == pulse_at + 1) begin
                Start_i = 1'b0;
            end
            if (c < 1 + 18*H) tick();
        end
        extra_bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (Busy_o !== 1'b0 || Done_o !== 1'b0 || CS_o !== 1'b1) extra_bad++;
        end
        vectors++;
        if (extra_bad != 0) begin
            miscompares++;
            $display("FAIL %s post_frame_idle: got %0d active cycles expected 0", name, extra_bad);
        end
        $display("frame %s: tx=%h rx=%h", name, d, Data_o);
    endtask

    task automatic test_reset();
        Reset    = 1'b0;
        Start_i  = 1'b0;
        Data_i   = 8'h00;
        loop_en  = 1'b1;
        miso_val = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({CS_o, SCK_o, MOSI_o, Busy_o, Done_o, Data_o} !== {5'b10000, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_state: got %b_%h expected 10000_00",
                     {CS_o, SCK_o, MOSI_o, Busy_o, Done_o}, Data_o);
        end
        Reset = 1'b1;
        tick();
        $display("reset: cs=%b sck=%b busy=%b data_o=%h", CS_o, SCK_o, Busy_o, Data_o);
    endtask

    task automatic test_loopback();
        run_frame(8'h55, 0, 0, "loop55");
    endtask

    task automatic test_tied_miso();
        run_frame(8'h00, 1, 0, "miso1");
        run_frame(8'hFF, 2, 0, "miso0");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        logic [7:0] rx_got [4];
        logic [7:0] sh;
        logic prev_cs, prev_sck;
        int falls, got, gap;
        bytes    = '{8'h55, 8'h33, 8'h0F, 8'h00};
        rx_got   = '{8'h00, 8'h00, 8'h00, 8'h00};
        sh       = 8'h00;
        prev_cs  = CS_o;
        prev_sck = SCK_o;
        falls    = 0;
        got      = 0;
        gap      = 100;
        loop_en  = 1'b1;
        Data_i   = bytes[0];
        Start_i  = 1'b1;
        for (int cyc = 0; cyc < 500 && got < 4; cyc++) begin
            tick();
            if (prev_cs && !CS_o) begin
                if (falls > 0) begin
                    vectors++;
                    if (gap < H) begin
                        miscompares++;
                        $display("FAIL b2b_gap frame %0d: got %0d cycles expected >= %0d", falls, gap, H);
                    end
                end
                falls++;
                if (falls < 4) Data_i = bytes[falls];
                else           Start_i = 1'b0;
            end
            if (!prev_cs && CS_o) gap = 1;
            else if (CS_o) gap++;
            if (!prev_sck && SCK_o && !CS_o) sh = {sh[6:0], MOSI_o};
            if (!prev_cs && CS_o) begin
                rx_got[got] = sh;
                got++;
            end
            if (Done_o && got > 0) begin
                vectors++;
                if (Data_o !== bytes[got-1]) begin
                    miscompares++;
                    $display("FAIL b2b_data_o frame %0d: got %h expected %h", got-1, Data_o, bytes[got-1]);
                end
            end
            prev_cs  = CS_o;
            prev_sck = SCK_o;
        end
        Start_i = 1'b0;
        vectors++;
        if (got != 4 || falls != 4) begin
            miscompares++;
            $display("FAIL b2b_frames: got %0d frames/%0d starts expected 4/4", got, falls);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rx_got[i] !== bytes[i]) begin
                miscompares++;
                $display("FAIL b2b_slave_byte %0d: got %h expected %h", i, rx_got[i], bytes[i]);
            end
            $display("b2b frame %0d: slave got %h", i, rx_got[i]);
        end
        for (int i = 0; i < 20 && Busy_o; i++) tick();
        repeat (2) tick();
    endtask

    task automatic test_start_while_busy();
        run_frame(8'h3C, 0, 20, "ignore_start");
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        loop_en = 1'b1;
        Data_i  = 8'hC3;
        Start_i = 1'b1;
        tick();
        Start_i = 1'b0;
        repeat (29) tick();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        vectors++;
        if ({CS_o, SCK_o, MOSI_o, Busy_o, Done_o, Data_o} !== {5'b10000, 8'h00}) begin
            miscompares++;
            $display("FAIL midframe_reset: got %b_%h expected 10000_00",
                     {CS_o, SCK_o, MOSI_o, Busy_o, Done_o}, Data_o);
        end
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (Done_o !== 1'b0 || CS_o !== 1'b1 || Busy_o !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL midframe_no_done: got %0d active cycles expected 0", bad);
        end
        $display("midframe reset: aborted frame, %0d active cycles after", bad);
        run_frame(8'h96, 0, 0, "after_reset");
    endtask

    task automatic test_idle();
        logic pcs, psck, pmosi;
        int toggles;
        Start_i = 1'b0;
        pcs     = CS_o;
        psck    = SCK_o;
        pmosi   = MOSI_o;
        toggles = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (CS_o !== pcs || SCK_o !== psck || MOSI_o !== pmosi) toggles++;
            pcs   = CS_o;
            psck  = SCK_o;
            pmosi = MOSI_o;
        end
        vectors++;
        if (toggles != 0 || {CS_o, SCK_o, MOSI_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL idle_pins: got %0d toggles, pins %b expected 0 toggles, 100",
                     toggles, {CS_o, SCK_o, MOSI_o});
        end
        $display("idle: %0d toggles over 200 cycles", toggles);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_tied_miso();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_frame();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
